// File: rtl/motor_pkg.sv
`default_nettype none
// ============================================================================
// Module   : motor_pkg
// Brief    : Shared types, limits and helpers for the wheel command path.
// Revision : 1.0 - initial release
// ============================================================================
package motor_pkg;

    // Signed wheel command, two's complement
    typedef logic signed [10:0] motor_cmd_t;

    // Usable command range; -1024 is excluded because the downstream
    // sign/magnitude stage only carries a 10-bit magnitude.
    localparam int MOTOR_MAX = 1023;
    localparam int MOTOR_MIN = -1023;

    // Ramp controller states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_TICK = 3'd1,
        ST_STEP_L    = 3'd2,
        ST_STEP_R    = 3'd3,
        ST_ESTOP     = 3'd4
    } ramp_state_t;

    // Clamp a raw 11-bit target into the usable range (only -1024 is outside)
    function automatic motor_cmd_t sat_cmd(input motor_cmd_t raw);
        if (raw[10] && (raw[9:0] == 10'd0)) begin
            return motor_cmd_t'(MOTOR_MIN);
        end
        return raw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ramp_step.sv
`default_nettype none
// ============================================================================
// Module   : ramp_step
// Brief    : Combinational slew step: move cur toward tgt by at most STEP,
//            landing exactly on tgt when it is within reach.
// Revision : 1.0 - initial release
// ============================================================================
module ramp_step
    import motor_pkg::*;
#(
    parameter int STEP = 8
) (
    input  logic signed [10:0] cur,
    input  logic signed [10:0] tgt,
    output logic signed [10:0] nxt
);

    localparam logic signed [11:0] c_step_wide = 12'(STEP);
    localparam logic signed [10:0] c_step      = 11'(STEP);

    logic signed [11:0] w_diff;
    logic signed [11:0] w_mag;
    logic signed [10:0] w_moved;

    // Distance to target in 12 bits so a full -1023..+1023 swing cannot wrap;
    // the moved value stays between cur and tgt, so 11 bits cannot overflow.
    always_comb begin
        w_diff  = $signed({tgt[10], tgt}) - $signed({cur[10], cur});
        w_mag   = w_diff[11] ? -w_diff : w_diff;
        w_moved = w_diff[11] ? (cur - c_step) : (cur + c_step);
        nxt     = (w_mag <= c_step_wide) ? tgt : w_moved;
    end

endmodule
`default_nettype wire

// File: rtl/motor_ramp.sv
`default_nettype none
// ============================================================================
// Module   : motor_ramp
// Brief    : Slew-rate limiter for left/right wheel commands with a fixed
//            ramp tick and an emergency-stop override forcing brake (0).
// Revision : 1.0 - initial release
// ============================================================================
module motor_ramp
    import motor_pkg::*;
#(
    parameter int TICK_DIV = 2048,
    parameter int STEP     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [10:0] tgt_lft,
    input  logic signed [10:0] tgt_rht,
    input  logic               tgt_vld,
    input  logic               estop,
    output logic signed [10:0] lft,
    output logic signed [10:0] rht,
    output logic               at_tgt
);

    localparam int                 c_cnt_w    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TICK_DIV - 1);

    ramp_state_t        r_state;
    ramp_state_t        w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic               w_tick;
    motor_cmd_t         r_tgt_lft;
    motor_cmd_t         r_tgt_rht;
    motor_cmd_t         r_lft;
    motor_cmd_t         r_rht;
    motor_cmd_t         w_cur;
    motor_cmd_t         w_tgt;
    motor_cmd_t         w_step_nxt;
    logic               w_sel_rht;
    logic               w_accept;
    logic               w_done;

    assign w_tick    = (r_cnt == c_cnt_last);
    // Targets are taken in any state except while stopping or stopped
    assign w_accept  = tgt_vld && !estop && (r_state != ST_ESTOP);
    // One step unit serves both channels: right during STEP_R, left otherwise
    assign w_sel_rht = (r_state == ST_STEP_R);
    assign w_cur     = w_sel_rht ? r_rht     : r_lft;
    assign w_tgt     = w_sel_rht ? r_tgt_rht : r_tgt_lft;
    // Evaluated in STEP_R: left already updated, right is being updated now
    assign w_done    = (r_lft == r_tgt_lft) && (w_step_nxt == r_tgt_rht);

    ramp_step #(
        .STEP (STEP)
    ) u_step (
        .cur (w_cur),
        .tgt (w_tgt),
        .nxt (w_step_nxt)
    );

    // Free-running tick divider, deliberately unaffected by targets or estop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_cnt_w'(1);
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; estop overrides everything
    always_comb begin
        w_state_nxt = r_state;
        if (estop) begin
            w_state_nxt = ST_ESTOP;
        end else begin
            case (r_state)
                ST_IDLE:      if (tgt_vld) w_state_nxt = ST_WAIT_TICK;
                ST_WAIT_TICK: if (w_tick)  w_state_nxt = ST_STEP_L;
                ST_STEP_L:    w_state_nxt = ST_STEP_R;
                // A target arriving now was not seen by this step's compare,
                // so keep ramping rather than declaring arrival.
                ST_STEP_R:    w_state_nxt = (w_done && !tgt_vld) ? ST_IDLE : ST_WAIT_TICK;
                ST_ESTOP:     w_state_nxt = ST_IDLE;
                default:      w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Target capture with saturation; estop clears targets to brake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tgt_lft <= '0;
            r_tgt_rht <= '0;
        end else if (estop) begin
            r_tgt_lft <= '0;
            r_tgt_rht <= '0;
        end else if (w_accept) begin
            r_tgt_lft <= sat_cmd(tgt_lft);
            r_tgt_rht <= sat_cmd(tgt_rht);
        end
    end

    // Command registers: one channel stepped per state, estop forces brake
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lft <= '0;
            r_rht <= '0;
        end else if (estop) begin
            r_lft <= '0;
            r_rht <= '0;
        end else if (r_state == ST_STEP_L) begin
            r_lft <= w_step_nxt;
        end else if (r_state == ST_STEP_R) begin
            r_rht <= w_step_nxt;
        end
    end

    assign lft    = r_lft;
    assign rht    = r_rht;
    assign at_tgt = (r_state == ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_motor_ramp.sv
`default_nettype none
// ============================================================================
// Module   : tb_motor_ramp
// Brief    : Directed self-checking bench for motor_ramp (STEP 8 and STEP 16
//            instances sharing stimulus, TICK_DIV 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_motor_ramp;

    logic               clk = 1'b0;
    logic               rst_n;
    logic signed [10:0] tgt_lft;
    logic signed [10:0] tgt_rht;
    logic               tgt_vld;
    logic               estop;
    logic signed [10:0] lft8;
    logic signed [10:0] rht8;
    logic               at_tgt8;
    logic signed [10:0] lft16;
    logic signed [10:0] rht16;
    logic               at_tgt16;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc;
    bit seen_bad;
    int exp_retgt[4] = '{40, 32, 24, 20};
    int exp_rev[5]   = '{24, 8, -8, -24, -40};

    always #5 clk = ~clk;

    motor_ramp #(
        .TICK_DIV (4),
        .STEP     (8)
    ) dut8 (
        .clk     (clk),
        .rst_n   (rst_n),
        .tgt_lft (tgt_lft),
        .tgt_rht (tgt_rht),
        .tgt_vld (tgt_vld),
        .estop   (estop),
        .lft     (lft8),
        .rht     (rht8),
        .at_tgt  (at_tgt8)
    );

    motor_ramp #(
        .TICK_DIV (4),
        .STEP     (16)
    ) dut16 (
        .clk     (clk),
        .rst_n   (rst_n),
        .tgt_lft (tgt_lft),
        .tgt_rht (tgt_rht),
        .tgt_vld (tgt_vld),
        .estop   (estop),
        .lft     (lft16),
        .rht     (rht16),
        .at_tgt  (at_tgt16)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge; leaves tgt_vld high for exactly one posedge
    task automatic pulse(input int l, input int r);
        tgt_lft = 11'(l);
        tgt_rht = 11'(r);
        tgt_vld = 1'b1;
        @(negedge clk);
        tgt_vld = 1'b0;
    endtask

    // Wait (bounded) for the selected left command to change
    task automatic wait_lft(input bit sel16, output int n);
        logic signed [10:0] prev;
        prev = sel16 ? lft16 : lft8;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (((sel16 ? lft16 : lft8) == prev) && (n < 40));
    endtask

    // Wait (bounded) for the selected instance to report arrival
    task automatic wait_idle(input bit sel16, input int limit);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sel16 ? at_tgt16 : at_tgt8) && (n < limit));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        tgt_lft = '0;
        tgt_rht = '0;
        tgt_vld = 1'b0;
        estop   = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_lft", lft8, 0);
        check("rst_rht", rht8, 0);
        check("rst_at_tgt", at_tgt8, 1);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("idle_lft", lft8, 0);
        check("idle_at_tgt", at_tgt8, 1);

        // Ramp 0 -> +100 in steps of 8, one step per 4 cycles
        pulse(100, 0);
        check("ramp_busy", at_tgt8, 0);
        for (int k = 1; k <= 13; k++) begin
            wait_lft(1'b0, cyc);
            check("ramp_lft", lft8, (8 * k > 100) ? 100 : 8 * k);
            check("ramp_rht", rht8, 0);
            if (k > 1) check("ramp_gap", cyc, 4);
        end
        check("ramp_at_tgt_lo", at_tgt8, 0);
        @(negedge clk);
        check("ramp_at_tgt_hi", at_tgt8, 1);

        // -1024 right target saturates to -1023
        pulse(100, -1024);
        seen_bad = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (rht8 == 11'h400) seen_bad = 1'b1;
        end while (!at_tgt8 && (cyc < 1500));
        check("sat_never_1024", seen_bad, 0);
        check("sat_rht", rht8, -1023);
        check("sat_lft", lft8, 100);
        check("sat_at_tgt", at_tgt8, 1);

        // Estop from a non-zero resting point; tgt_vld during estop ignored
        estop = 1'b1;
        @(negedge clk);
        check("estop_lft", lft8, 0);
        check("estop_rht", rht8, 0);
        check("estop_at_tgt", at_tgt8, 0);
        pulse(300, 300);
        check("estop_hold_lft", lft8, 0);
        check("estop_hold_at_tgt", at_tgt8, 0);
        estop = 1'b0;
        @(negedge clk);
        check("estop_rel_at_tgt", at_tgt8, 1);
        repeat (12) @(negedge clk);
        check("estop_vld_ignored", lft8, 0);
        check("estop_idle_kept", at_tgt8, 1);

        // Estop mid-ramp at +56
        pulse(200, 0);
        for (int k = 1; k <= 7; k++) wait_lft(1'b0, cyc);
        check("pre_estop_lft", lft8, 56);
        estop = 1'b1;
        @(negedge clk);
        check("mid_estop_lft", lft8, 0);
        check("mid_estop_rht", rht8, 0);
        check("mid_estop_at_tgt", at_tgt8, 0);
        estop = 1'b0;
        @(negedge clk);
        check("mid_estop_rel", at_tgt8, 1);

        // Retarget to +20 while ramping from +48 toward +200
        pulse(200, 0);
        for (int k = 1; k <= 6; k++) wait_lft(1'b0, cyc);
        check("pre_retgt_lft", lft8, 48);
        pulse(20, 0);
        for (int k = 0; k < 4; k++) begin
            wait_lft(1'b0, cyc);
            check("retgt_lft", lft8, exp_retgt[k]);
        end
        check("retgt_at_tgt_lo", at_tgt8, 0);
        @(negedge clk);
        check("retgt_at_tgt_hi", at_tgt8, 1);

        // Asynchronous reset mid-flight, no clock edge needed
        rst_n = 1'b0;
        #1;
        check("async_rst_lft8", lft8, 0);
        check("async_rst_lft16", lft16, 0);
        check("async_rst_at_tgt16", at_tgt16, 1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Sign reversal +40 -> -40 with STEP 16 passes through the range cleanly
        pulse(40, 0);
        wait_idle(1'b1, 100);
        check("rev_start", lft16, 40);
        pulse(-40, 0);
        for (int k = 0; k < 5; k++) begin
            wait_lft(1'b1, cyc);
            check("rev_lft", lft16, exp_rev[k]);
        end
        @(negedge clk);
        check("rev_at_tgt", at_tgt16, 1);

        // Re-issuing the current target still runs one pass then returns idle
        pulse(-40, 0);
        check("retrig_busy", at_tgt16, 0);
        wait_idle(1'b1, 100);
        check("retrig_idle", at_tgt16, 1);
        check("retrig_lft", lft16, -40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
